// File: rtl/k_and_s_pkg.sv
// Shared types for the K&S datapath: decoded instruction set,
// ALU operation codes and the opcode map.
package k_and_s_pkg;

   typedef enum logic [4:0] {
      I_NOP,
      I_LOAD,
      I_STORE,
      I_MOVE,
      I_ADD,
      I_SUB,
      I_AND,
      I_OR,
      I_XOR,
      I_BRANCH,
      I_BZERO,
      I_BNZERO,
      I_BNEG,
      I_BNNEG,
      I_BOV,
      I_BNOV,
      I_HALT
   } decoded_instruction_type;

   typedef enum logic [2:0] {
      ALU_OR    = 3'd0,
      ALU_ADD   = 3'd1,
      ALU_SUB   = 3'd2,
      ALU_AND   = 3'd3,
      ALU_XOR   = 3'd4,
      ALU_PASSA = 3'd5
   } alu_op_t;

   localparam logic [7:0] OP_NOP    = 8'h00;
   localparam logic [7:0] OP_BRANCH = 8'h01;
   localparam logic [7:0] OP_BZERO  = 8'h02;
   localparam logic [7:0] OP_BNEG   = 8'h03;
   localparam logic [7:0] OP_BOV    = 8'h05;
   localparam logic [7:0] OP_BNOV   = 8'h06;
   localparam logic [7:0] OP_BNNEG  = 8'h0A;
   localparam logic [7:0] OP_BNZERO = 8'h0B;
   localparam logic [7:0] OP_LOAD   = 8'h81;
   localparam logic [7:0] OP_STORE  = 8'h82;
   localparam logic [7:0] OP_MOVE   = 8'h91;
   localparam logic [7:0] OP_ADD    = 8'hA1;
   localparam logic [7:0] OP_SUB    = 8'hA2;
   localparam logic [7:0] OP_AND    = 8'hA3;
   localparam logic [7:0] OP_OR     = 8'hA4;
   localparam logic [7:0] OP_XOR    = 8'hA5;
   localparam logic [7:0] OP_HALT   = 8'hFF;

   function automatic decoded_instruction_type decode_op(
      input logic [7:0] op
   );
      case (op)
         OP_NOP:    return I_NOP;
         OP_BRANCH: return I_BRANCH;
         OP_BZERO:  return I_BZERO;
         OP_BNEG:   return I_BNEG;
         OP_BOV:    return I_BOV;
         OP_BNOV:   return I_BNOV;
         OP_BNNEG:  return I_BNNEG;
         OP_BNZERO: return I_BNZERO;
         OP_LOAD:   return I_LOAD;
         OP_STORE:  return I_STORE;
         OP_MOVE:   return I_MOVE;
         OP_ADD:    return I_ADD;
         OP_SUB:    return I_SUB;
         OP_AND:    return I_AND;
         OP_OR:     return I_OR;
         OP_XOR:    return I_XOR;
         OP_HALT:   return I_HALT;
         default:   return I_NOP;
      endcase
   endfunction

endpackage

// File: rtl/ks_alu.sv
// Combinational K&S ALU: one shared adder for ADD/SUB plus logic ops,
// with zero/negative/carry/overflow status for every operation.
module ks_alu
   import k_and_s_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic [2:0]        op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] res,
   output logic              zero,
   output logic              neg,
   output logic              uovf,
   output logic              sovf
);

   logic              sub;
   logic              c_msb;
   logic [DATA_W-1:0] b_eff;
   logic [DATA_W:0]   sum;

   assign sub   = (op == ALU_SUB);
   assign b_eff = sub ? ~b : b;
   assign sum   = {1'b0, a} + {1'b0, b_eff}
                + {{DATA_W{1'b0}}, sub};

   // carry into the MSB recovered from the MSB sum bit
   assign c_msb = sum[DATA_W-1] ^ a[DATA_W-1] ^ b_eff[DATA_W-1];

   always_comb begin
      res  = a | b;
      uovf = 1'b0;
      sovf = 1'b0;
      case (op)
         ALU_ADD, ALU_SUB: begin
            res  = sum[DATA_W-1:0];
            uovf = sum[DATA_W] ^ sub;
            sovf = c_msb ^ sum[DATA_W];
         end
         ALU_AND:   res = a & b;
         ALU_XOR:   res = a ^ b;
         ALU_PASSA: res = a;
         default:   res = a | b;
      endcase
   end

   assign zero = (res == '0);
   assign neg  = res[DATA_W-1];

endmodule

// File: rtl/ks_data_path_param.sv
// K&S datapath: PC, IR, register file, ALU, registered flags and the
// RAM address mux, steered entirely by the control unit's strobes.
module ks_data_path_param
   import k_and_s_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 5,
   parameter int NREGS    = 4,
   parameter int RESET_PC = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    branch,
   input  logic                    pc_enable,
   input  logic                    ir_enable,
   input  logic                    addr_sel,
   input  logic                    c_sel,
   input  logic [2:0]              operation,
   input  logic                    write_reg_enable,
   input  logic                    flags_reg_enable,
   output decoded_instruction_type decoded_instruction,
   output logic                    zero_op,
   output logic                    neg_op,
   output logic                    unsigned_overflow,
   output logic                    signed_overflow,
   output logic [ADDR_W-1:0]       ram_addr,
   output logic [DATA_W-1:0]       data_out,
   input  logic [DATA_W-1:0]       data_in
);

   localparam int RIDX_W = $clog2(NREGS);

   if (DATA_W < 16 || NREGS < 2 ||
       (NREGS & (NREGS - 1)) != 0 ||
       3 * RIDX_W > DATA_W - 8 ||
       ADDR_W + RIDX_W > DATA_W - 8) begin : g_bad_param
      $error("ks_data_path_param: illegal DATA_W/ADDR_W/NREGS");
   end

   logic [ADDR_W-1:0]       pc;
   logic [DATA_W-1:0]       ir;
   logic [DATA_W-1:0]       regs [NREGS];
   logic [ADDR_W-1:0]       mem;
   logic [7:0]              opcode;
   decoded_instruction_type dec;
   logic                    is_alu;
   logic [RIDX_W-1:0]       a_addr;
   logic [RIDX_W-1:0]       b_addr;
   logic [RIDX_W-1:0]       c_addr;
   logic [DATA_W-1:0]       rd_a;
   logic [DATA_W-1:0]       rd_b;
   logic [DATA_W-1:0]       alu_res;
   logic                    alu_zero;
   logic                    alu_neg;
   logic                    alu_uovf;
   logic                    alu_sovf;
   logic                    unused_ir_bits;

   assign opcode = ir[DATA_W-1 -: 8];
   assign mem    = ir[ADDR_W-1:0];
   assign dec    = decode_op(opcode);
   assign is_alu = dec inside {I_ADD, I_SUB, I_AND,
                               I_OR, I_XOR};

   assign decoded_instruction = dec;

   // IR bits between the opcode and the operand fields are don't-care
   assign unused_ir_bits = ^ir;

   always_comb begin
      a_addr = '0;
      b_addr = '0;
      c_addr = '0;
      unique case (1'b1)
         dec == I_LOAD:  c_addr = ir[ADDR_W +: RIDX_W];
         dec == I_STORE: a_addr = ir[ADDR_W +: RIDX_W];
         dec == I_MOVE: begin
            c_addr = ir[RIDX_W +: RIDX_W];
            a_addr = ir[0 +: RIDX_W];
            b_addr = ir[0 +: RIDX_W];
         end
         is_alu: begin
            a_addr = ir[0 +: RIDX_W];
            b_addr = ir[RIDX_W +: RIDX_W];
            c_addr = ir[2*RIDX_W +: RIDX_W];
         end
         default: ;
      endcase
   end

   assign rd_a = regs[a_addr];
   assign rd_b = regs[b_addr];

   ks_alu #(
      .DATA_W (DATA_W)
   ) u_alu (
      .op   (operation),
      .a    (rd_a),
      .b    (rd_b),
      .res  (alu_res),
      .zero (alu_zero),
      .neg  (alu_neg),
      .uovf (alu_uovf),
      .sovf (alu_sovf)
   );

   assign ram_addr = addr_sel ? mem : pc;
   assign data_out = rd_a;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc                <= RESET_PC[ADDR_W-1:0];
         ir                <= '0;
         zero_op           <= 1'b0;
         neg_op            <= 1'b0;
         unsigned_overflow <= 1'b0;
         signed_overflow   <= 1'b0;
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else begin
         if (pc_enable) begin
            pc <= branch ? mem : pc + ADDR_W'(1);
         end
         if (ir_enable) begin
            ir <= data_in;
         end
         if (write_reg_enable) begin
            regs[c_addr] <= c_sel ? alu_res : data_in;
         end
         if (flags_reg_enable) begin
            zero_op           <= alu_zero;
            neg_op            <= alu_neg;
            unsigned_overflow <= alu_uovf;
            signed_overflow   <= alu_sovf;
         end
      end
   end

endmodule

// File: tb/tb_ks_data_path_param.sv
// Scoreboard bench: an arithmetic reference model predicts each cycle's
// outputs into a queue; a negedge monitor pops and compares them.
module tb_ks_data_path_param;
   import k_and_s_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        rst_n;
      logic        branch;
      logic        pc_enable;
      logic        ir_enable;
      logic        addr_sel;
      logic        c_sel;
      logic [2:0]  operation;
      logic        write_reg_enable;
      logic        flags_reg_enable;
      logic [23:0] data_in;
   } ctl_t;

   typedef struct packed {
      logic                    d24;
      logic [7:0]              ra;
      logic [23:0]             dout;
      decoded_instruction_type dec;
      logic [3:0]              fl;
   } exp_t;

   localparam ctl_t IDLE = ctl_t'({1'b1, 34'd0});

   ctl_t c, c16, c24;
   exp_t e24;
   exp_t q[$];
   string tq[$];
   int n_chk = 0;
   int n_pass = 0;

   decoded_instruction_type dec16, dec24;
   logic z16, n16, u16, s16;
   logic z24, n24, u24, s24;
   logic [4:0]  ra16;
   logic [15:0] do16;
   logic [7:0]  ra24;
   logic [23:0] do24;

   ks_data_path_param dut16 (
      .clk(clk), .rst_n(c16.rst_n), .branch(c16.branch),
      .pc_enable(c16.pc_enable), .ir_enable(c16.ir_enable),
      .addr_sel(c16.addr_sel), .c_sel(c16.c_sel),
      .operation(c16.operation),
      .write_reg_enable(c16.write_reg_enable),
      .flags_reg_enable(c16.flags_reg_enable),
      .decoded_instruction(dec16), .zero_op(z16), .neg_op(n16),
      .unsigned_overflow(u16), .signed_overflow(s16),
      .ram_addr(ra16), .data_out(do16),
      .data_in(c16.data_in[15:0])
   );

   ks_data_path_param #(
      .DATA_W(24), .ADDR_W(8), .NREGS(8), .RESET_PC(0)
   ) dut24 (
      .clk(clk), .rst_n(c24.rst_n), .branch(c24.branch),
      .pc_enable(c24.pc_enable), .ir_enable(c24.ir_enable),
      .addr_sel(c24.addr_sel), .c_sel(c24.c_sel),
      .operation(c24.operation),
      .write_reg_enable(c24.write_reg_enable),
      .flags_reg_enable(c24.flags_reg_enable),
      .decoded_instruction(dec24), .zero_op(z24), .neg_op(n24),
      .unsigned_overflow(u24), .signed_overflow(s24),
      .ram_addr(ra24), .data_out(do24),
      .data_in(c24.data_in)
   );

   // reference model state of the 16-bit instance
   int          m_pc;
   logic [15:0] m_ir;
   logic [15:0] m_r [4];
   logic [3:0]  m_fl;

   logic [7:0] ops [17] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h05,
                            8'h06, 8'h0A, 8'h0B, 8'h81, 8'h82,
                            8'h91, 8'hA1, 8'hA2, 8'hA3, 8'hA4,
                            8'hA5, 8'hFF};

   task automatic chk(string name, logic [23:0] act,
                      logic [23:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   function automatic decoded_instruction_type dec_of(int op);
      case (op)
         'h01: return I_BRANCH;
         'h02: return I_BZERO;
         'h03: return I_BNEG;
         'h05: return I_BOV;
         'h06: return I_BNOV;
         'h0A: return I_BNNEG;
         'h0B: return I_BNZERO;
         'h81: return I_LOAD;
         'h82: return I_STORE;
         'h91: return I_MOVE;
         'hA1: return I_ADD;
         'hA2: return I_SUB;
         'hA3: return I_AND;
         'hA4: return I_OR;
         'hA5: return I_XOR;
         'hFF: return I_HALT;
         default: return I_NOP;
      endcase
   endfunction

   function automatic int fld(logic [15:0] ir, int pos);
      return (int'(ir) >> pos) % 4;
   endfunction

   task automatic fields(input logic [15:0] ir,
                         output int a, output int b, output int cc);
      decoded_instruction_type d;
      d = dec_of(int'(ir) >> 8);
      a = 0;
      b = 0;
      cc = 0;
      if (d == I_LOAD) cc = fld(ir, 5);
      else if (d == I_STORE) a = fld(ir, 5);
      else if (d == I_MOVE) begin
         cc = fld(ir, 2);
         a = fld(ir, 0);
         b = a;
      end else if (d inside {I_ADD, I_SUB, I_AND, I_OR, I_XOR}) begin
         a = fld(ir, 0);
         b = fld(ir, 2);
         cc = fld(ir, 4);
      end
   endtask

   task automatic ref_alu(input int op, input int a, input int b,
                          output int res, output logic [3:0] fl);
      int sa, sb, sr;
      bit u, s;
      sa = (a >= 32768) ? a - 65536 : a;
      sb = (b >= 32768) ? b - 65536 : b;
      u = 0;
      s = 0;
      case (op)
         1: begin
            res = a + b;
            u = res > 65535;
            sr = sa + sb;
            s = (sr > 32767) || (sr < -32768);
         end
         2: begin
            res = a - b;
            u = a < b;
            sr = sa - sb;
            s = (sr > 32767) || (sr < -32768);
         end
         3: res = a & b;
         4: res = a ^ b;
         5: res = a;
         default: res = a | b;
      endcase
      res = res & 65535;
      fl = {res == 0, res >= 32768, u, s};
   endtask

   task automatic step(string tag, bit d24, bit push);
      exp_t e;
      int a, b, cc, res;
      logic [3:0] fl;
      @(posedge clk);
      #1;
      if (d24) begin
         c24 = c;
         c16 = IDLE;
         e = e24;
      end else begin
         c16 = c;
         c24 = IDLE;
         fields(m_ir, a, b, cc);
         e.d24 = 1'b0;
         e.ra = c.addr_sel ? 8'(int'(m_ir) % 32) : 8'(m_pc);
         e.dout = {8'h0, m_r[a]};
         e.dec = dec_of(int'(m_ir) >> 8);
         e.fl = m_fl;
         ref_alu(int'(c.operation), int'(m_r[a]), int'(m_r[b]),
                 res, fl);
         if (!c.rst_n) begin
            m_pc = 0;
            m_ir = '0;
            foreach (m_r[i]) m_r[i] = '0;
            m_fl = '0;
         end else begin
            if (c.write_reg_enable)
               m_r[cc] = c.c_sel ? 16'(res) : c.data_in[15:0];
            if (c.flags_reg_enable) m_fl = fl;
            if (c.pc_enable)
               m_pc = c.branch ? int'(m_ir) % 32 : (m_pc + 1) % 32;
            if (c.ir_enable) m_ir = c.data_in[15:0];
         end
      end
      if (push) begin
         q.push_back(e);
         tq.push_back(tag);
      end
   endtask

   task automatic ir_load(string tag, logic [15:0] v);
      c = IDLE;
      c.ir_enable = 1'b1;
      c.data_in = {8'h0, v};
      step(tag, 0, 1);
   endtask

   task automatic ld(int r, logic [15:0] v);
      ir_load("ld_ir", 16'h8100 | 16'(r << 5));
      c = IDLE;
      c.write_reg_enable = 1'b1;
      c.data_in = {8'h0, v};
      step("ld_wr", 0, 1);
   endtask

   task automatic alu_go(string tag, logic [2:0] op, bit wr, bit fe);
      c = IDLE;
      c.operation = op;
      c.c_sel = 1'b1;
      c.write_reg_enable = wr;
      c.flags_reg_enable = fe;
      step(tag, 0, 1);
   endtask

   task automatic x24(string tag, logic [7:0] ra, logic [23:0] d,
                      decoded_instruction_type dec, logic [3:0] fl);
      e24 = '{d24: 1'b1, ra: ra, dout: d, dec: dec, fl: fl};
      step(tag, 1, 1);
   endtask

   always @(negedge clk) begin
      exp_t e;
      string t;
      if (q.size() > 0) begin
         e = q.pop_front();
         t = tq.pop_front();
         if (e.d24) begin
            chk({t, ".ram_addr"}, {16'h0, ra24}, {16'h0, e.ra});
            chk({t, ".data_out"}, do24, e.dout);
            chk({t, ".decode"}, 24'(dec24), 24'(e.dec));
            chk({t, ".flags"}, {20'h0, z24, n24, u24, s24},
                {20'h0, e.fl});
         end else begin
            chk({t, ".ram_addr"}, {19'h0, ra16}, {16'h0, e.ra});
            chk({t, ".data_out"}, {8'h0, do16}, e.dout);
            chk({t, ".decode"}, 24'(dec16), 24'(e.dec));
            chk({t, ".flags"}, {20'h0, z16, n16, u16, s16},
                {20'h0, e.fl});
         end
      end
   end

   initial begin
      c = IDLE;
      c16 = IDLE;
      c24 = IDLE;
      e24 = '0;

      c = '1;
      c.rst_n = 1'b0;
      step("rst_all_en", 0, 0);
      c = IDLE;
      step("reset", 0, 1);

      ld(0, 16'h7FFF);
      ld(1, 16'h0001);
      ir_load("add_ir", 16'hA124);
      alu_go("add", 3'd1, 1, 1);
      ir_load("add_st", 16'h8240);
      c = IDLE;
      step("add_result", 0, 1);

      ld(0, 16'd5);
      ld(1, 16'd7);
      ir_load("sub_ir", 16'hA234);
      alu_go("sub", 3'd2, 1, 1);
      ir_load("sub_st", 16'h8260);
      c = IDLE;
      step("sub_result", 0, 1);
      ld(0, 16'd7);
      ir_load("sub_eq_ir", 16'hA234);
      alu_go("sub_eq", 3'd2, 0, 1);
      c = IDLE;
      step("sub_eq_flags", 0, 1);

      alu_go("add_nz", 3'd1, 0, 1);
      alu_go("sub_hold", 3'd2, 1, 0);
      c = IDLE;
      step("flag_hold", 0, 1);

      ir_load("br31_ir", 16'h011F);
      c = IDLE;
      c.pc_enable = 1'b1;
      c.branch = 1'b1;
      step("br31", 0, 1);
      c = IDLE;
      step("pc31", 0, 1);
      c = IDLE;
      c.pc_enable = 1'b1;
      step("wrap", 0, 1);
      c = IDLE;
      step("pc0", 0, 1);
      ir_load("br14_ir", 16'h0114);
      c = IDLE;
      c.pc_enable = 1'b1;
      c.branch = 1'b1;
      step("br14", 0, 1);
      c = IDLE;
      step("pc14", 0, 1);
      c = IDLE;
      c.addr_sel = 1'b1;
      step("mem_sel", 0, 1);

      for (int i = 0; i < 800; i++) begin
         c.rst_n = ($urandom_range(0, 39) != 0);
         c.branch = 1'($urandom);
         c.pc_enable = 1'($urandom);
         c.ir_enable = 1'($urandom);
         c.addr_sel = 1'($urandom);
         c.c_sel = 1'($urandom);
         c.operation = 3'($urandom);
         c.write_reg_enable = 1'($urandom);
         c.flags_reg_enable = 1'($urandom);
         c.data_in = {8'h0,
                      ($urandom_range(0, 3) != 0) ?
                         ops[$urandom_range(0, 16)] : 8'($urandom),
                      8'($urandom)};
         step("rand", 0, 1);
      end

      c = '1;
      c.rst_n = 1'b0;
      step("rst24", 1, 0);
      c = IDLE;
      x24("p_reset", 8'h00, 24'h0, I_NOP, 4'h0);
      c = IDLE;
      c.ir_enable = 1'b1;
      c.data_in = 24'h8105C3;
      x24("p_ld_ir", 8'h00, 24'h0, I_NOP, 4'h0);
      c = IDLE;
      c.addr_sel = 1'b1;
      c.write_reg_enable = 1'b1;
      c.data_in = 24'h123456;
      x24("p_ld", 8'hC3, 24'h0, I_LOAD, 4'h0);
      c = IDLE;
      c.ir_enable = 1'b1;
      c.pc_enable = 1'b1;
      c.data_in = 24'h820500;
      x24("p_st_ir", 8'h00, 24'h0, I_LOAD, 4'h0);
      c = IDLE;
      x24("p_pc1", 8'h01, 24'h123456, I_STORE, 4'h0);

      c = IDLE;
      step("drain", 0, 0);
      @(negedge clk);
      #1;
      chk("scoreboard_drained", 24'(q.size()), 24'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
